// File: rtl/decade_down_counter_pkg.sv
// decade_down_counter_pkg: shared BCD digit type, limit and clamp helper
package decade_down_counter_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit of the countdown, next value plus borrow to the next digit
module bcd_down_digit
  import decade_down_counter_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       borrow_i,
  input  logic       load_en_i,
  input  bcd_digit_t load_val_i,
  output bcd_digit_t digit_o,
  output logic       borrow_o,
  output logic       is_zero_o
);
  assign is_zero_o = (digit_i == 4'd0);
  assign borrow_o  = borrow_i && is_zero_o;
  assign digit_o   = load_en_i ? bcd_clamp(load_val_i) :
                     !borrow_i ? digit_i :
                     is_zero_o ? BCD_MAX : digit_i - 4'd1;
endmodule

// File: rtl/decade_down_counter.sv
// decade_down_counter: multi-digit BCD countdown timer with auto-reload or one-shot stop
module decade_down_counter
  import decade_down_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    Clk_In,
  input  logic                    Reset_In,
  input  logic                    Enable_In,
  input  logic                    Start_Counter_Command_In,
  input  logic                    Stop_Counter_Command_In,
  input  logic                    Load_Counter_Value_Command_In,
  input  logic                    Auto_Reload_In,
  input  logic [4*NUM_DIGITS-1:0] Preload_Counter_Value_In,
  output logic                    Counter_Running_Flag_Out,
  output logic                    Counter_Borrow_Flag_Out,
  output logic                    Counter_Done_Flag_Out,
  output logic [4*NUM_DIGITS-1:0] Counter_Count_Out
);
  localparam int W = 4 * NUM_DIGITS;
  logic [W-1:0] count_q, count_d, reload_q, reload_d, load_val;
  logic running_q, running_d, done_q, done_d, borrow_q, borrow_d;
  logic [NUM_DIGITS-1:0] zero_v;
  logic [NUM_DIGITS:0] brw;
  logic load_cmd, zero_hit, finish;
  // The digit chain always decrements while running; the final borrow marks an all-zero count,
  // and that case is turned into a load of either the reload value or zero.
  assign brw[0]   = running_q;
  assign zero_hit = brw[NUM_DIGITS] && (&zero_v);
  assign load_cmd = !running_q && Load_Counter_Value_Command_In;
  assign finish   = zero_hit && !Auto_Reload_In;
  assign load_val = !running_q ? Preload_Counter_Value_In : Auto_Reload_In ? reload_q : '0;
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_down_digit u_digit (
        .digit_i   (count_q[4*g +: 4]),
        .borrow_i  (brw[g]),
        .load_en_i (load_cmd || zero_hit),
        .load_val_i(load_val[4*g +: 4]),
        .digit_o   (count_d[4*g +: 4]),
        .borrow_o  (brw[g+1]),
        .is_zero_o (zero_v[g])
      );
    end
  endgenerate
  // Next-state for the control flags and reload register
  always_comb begin
    reload_d  = load_cmd ? count_d : reload_q;
    running_d = Start_Counter_Command_In ? 1'b1 : (Stop_Counter_Command_In || finish) ? 1'b0 : running_q;
    done_d    = (load_cmd || Start_Counter_Command_In) ? 1'b0 : finish ? 1'b1 : done_q;
    borrow_d  = zero_hit && Auto_Reload_In;
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      count_q   <= '0;
      reload_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      borrow_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      done_q    <= done_d;
      borrow_q  <= borrow_d;
    end
  end
  assign Counter_Count_Out        = Enable_In ? count_q   : 'z;
  assign Counter_Running_Flag_Out = Enable_In ? running_q : 1'bz;
  assign Counter_Borrow_Flag_Out  = Enable_In ? borrow_q  : 1'bz;
  assign Counter_Done_Flag_Out    = Enable_In ? done_q    : 1'bz;
endmodule
